rotate_stepper: RTL and testbench

- Sequential source stage that sits directly upstream of the combinational multibit rotator and drives its data and direction inputs.
- Loads an N-bit seed on START, then emits a sequence of successive rotations by M bits, one word per output handshake, for a run-time number of steps.
- Replaces the manual "feed YY back into XX" loop with a clocked register that a downstream consumer drains through a valid/ready interface.

---
 rtl/rotate_pkg.sv | 15 +
 rtl/rotate_stepper_rotator.sv | 29 ++
 rtl/rotate_stepper.sv | 113 +++++++++++
 tb/tb_rotate_stepper.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate stepper and its rotator.
package rotate_pkg;

    // Run-control FSM states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    // Direction encoding on DIR / latched direction
    localparam logic DirRight = 1'b1;
    localparam logic DirLeft  = 1'b0;

endpackage

// File: rtl/rotate_stepper_rotator.sv
// Combinational multibit rotator: rotates din_i by M bits in the direction dir_i.
// Right moves the M LSBs to the top, left moves the M MSBs to the bottom; M = 0 is identity.
module rotate_stepper_rotator
    import rotate_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 3
) (
    input  logic [N-1:0] din_i,
    input  logic         dir_i,
    output logic [N-1:0] dout_o
);

    logic [N-1:0] rot_right;
    logic [N-1:0] rot_left;

    // A shift by N in an N-bit context yields zero, so M = 0 collapses to identity
    assign rot_right = (din_i >> M) | (din_i << (N - M));
    assign rot_left  = (din_i << M) | (din_i >> (N - M));

    // Select the rotation matching the requested direction
    always_comb begin
        dout_o = rot_left;
        if (dir_i == DirRight) begin
            dout_o = rot_right;
        end
    end

endmodule

// File: rtl/rotate_stepper.sv
// Rotate stepper: loads a seed on START and emits NSTEPS successive M-bit rotations
// through a registered valid/ready interface, then pulses DONE.
module rotate_stepper
    import rotate_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned M  = 3,
    parameter int unsigned CW = 8
) (
    input  logic          CLK,
    input  logic          N_RESET,
    input  logic          START,
    input  logic [N-1:0]  DIN,
    input  logic          DIR,
    input  logic [CW-1:0] NSTEPS,
    output logic [N-1:0]  DOUT,
    output logic          DOUT_VALID,
    input  logic          DOUT_READY,
    output logic          BUSY,
    output logic          DONE
);

    state_e        state_q, state_d;
    logic [N-1:0]  dout_q, dout_d;
    logic [CW-1:0] count_q, count_d;
    logic          dir_q, dir_d;

    logic [N-1:0]  rot_in;
    logic          rot_dir;
    logic [N-1:0]  rot_out;

    // Rotator sees the seed and live DIR while idle, the current word and latched DIR otherwise
    always_comb begin
        rot_in  = dout_q;
        rot_dir = dir_q;
        if (state_q == StIdle) begin
            rot_in  = DIN;
            rot_dir = DIR;
        end
    end

    rotate_stepper_rotator #(
        .N (N),
        .M (M)
    ) u_rotator (
        .din_i  (rot_in),
        .dir_i  (rot_dir),
        .dout_o (rot_out)
    );

    // Next-state logic for run control, word register, step counter and direction
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        count_d = count_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    dir_d = DIR;
                    if (NSTEPS != '0) begin
                        dout_d  = rot_out;
                        count_d = NSTEPS;
                        state_d = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRun: begin
                // DOUT_VALID is always high in this state, so READY alone completes a handshake
                if (DOUT_READY) begin
                    count_d = count_q - CW'(1);
                    if (count_q != CW'(1)) begin
                        dout_d = rot_out;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            state_q <= StIdle;
            dout_q  <= '0;
            count_q <= '0;
            dir_q   <= DirLeft;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    // Moore outputs decoded from registered state only
    always_comb begin
        DOUT       = dout_q;
        DOUT_VALID = (state_q == StRun);
        BUSY       = (state_q != StIdle);
        DONE       = (state_q == StFin);
    end

endmodule

// File: tb/tb_rotate_stepper.sv
// Self-checking bench for rotate_stepper: directed and randomized runs against a
// bit-index reference model of "seed rotated by k*M mod N".
module tb_rotate_stepper;

    localparam int N  = 8;
    localparam int M  = 3;
    localparam int CW = 8;

    logic          CLK;
    logic          N_RESET;
    logic          START;
    logic [N-1:0]  DIN;
    logic          DIR;
    logic [CW-1:0] NSTEPS;
    logic [N-1:0]  DOUT;
    logic          DOUT_VALID;
    logic          DOUT_READY;
    logic          BUSY;
    logic          DONE;

    int total = 0;
    int bad   = 0;
    logic [N-1:0] last_word = '0;

    rotate_stepper #(
        .N  (N),
        .M  (M),
        .CW (CW)
    ) dut (
        .CLK        (CLK),
        .N_RESET    (N_RESET),
        .START      (START),
        .DIN        (DIN),
        .DIR        (DIR),
        .NSTEPS     (NSTEPS),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: word k of a run is x rotated by (k*M mod N); bit-index form
    function automatic logic [N-1:0] model(input logic [N-1:0] x, input logic d, input int k);
        logic [N-1:0] y;
        int r;
        r = (k * M) % N;
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (d) y[i] = x[(i + r) % N];
            else   y[(i + r) % N] = x[i];
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: mode 0 = READY high, 1 = random READY, 2 = fixed pattern 0,0,1,0,1,1.
    // noise = drive START/DIN=F0/random DIR while busy; all of it must be ignored.
    task automatic run(input logic [N-1:0] din, input logic dir, input int ns,
                       input int mode, input bit noise);
        int k;
        int cyc;
        logic rdy;
        logic [5:0] pat;
        pat = 6'b110100;  // LSB first: 0,0,1,0,1,1
        k   = 1;
        cyc = 0;
        @(negedge CLK);
        START = 1'b1; DIN = din; DIR = dir; NSTEPS = CW'(ns); DOUT_READY = 1'b0;
        @(negedge CLK);
        while (k <= ns && cyc < 2000) begin
            START = noise;
            if (noise) begin
                DIN = 8'hF0;
                DIR = 1'($urandom_range(0, 1));
            end
            chk("valid", DOUT_VALID, 1);
            chk("busy", BUSY, 1);
            chk("done_run", DONE, 0);
            chk("word", DOUT, model(din, dir, k));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 6) ? pat[cyc] : 1'b1;
            endcase
            DOUT_READY = rdy;
            @(negedge CLK);
            cyc++;
            if (rdy) k++;
        end
        chk("timeout", (cyc < 2000), 1);
        if (ns > 0) last_word = model(din, dir, ns);
        // FIN cycle
        DOUT_READY = 1'($urandom_range(0, 1));
        chk("fin_valid", DOUT_VALID, 0);
        chk("fin_done", DONE, 1);
        chk("fin_busy", BUSY, 1);
        chk("fin_dout", DOUT, last_word);
        START = noise;
        DIN   = 8'hF0;
        @(negedge CLK);
        // Back in IDLE
        chk("idle_done", DONE, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_valid", DOUT_VALID, 0);
        chk("idle_dout", DOUT, last_word);
        START = 1'b0;
        DOUT_READY = 1'b0;
    endtask

    initial begin
        N_RESET = 1'b0; START = 1'b0; DIN = '0; DIR = 1'b0; NSTEPS = '0; DOUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_dout", DOUT, 0);
        chk("rst_valid", DOUT_VALID, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        N_RESET = 1'b1;

        run(8'b10101100, 1'b1, 8, 0, 1'b0);   // right, full cycle back to seed
        run(8'b10101100, 1'b0, 2, 0, 1'b0);   // left, two words
        run(8'b10101100, 1'b1, 3, 2, 1'b1);   // backpressure pattern, DIR flipped mid-run
        run(8'h5A, 1'b0, 0, 0, 1'b0);         // zero length
        run(8'b10101100, 1'b1, 4, 1, 1'b1);   // START F0 during RUN and FIN ignored
        run(8'($urandom), 1'($urandom_range(0, 1)), 255, 1, 1'b1);  // max count, no wrap
        for (int i = 0; i < 8; i++) begin
            run(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-run after the 2nd word
        @(negedge CLK);
        START = 1'b1; DIN = 8'b10101100; DIR = 1'b1; NSTEPS = CW'(5);
        @(negedge CLK);
        START = 1'b0; DOUT_READY = 1'b1;
        chk("ar_word1", DOUT, model(8'b10101100, 1'b1, 1));
        @(negedge CLK);
        chk("ar_word2", DOUT, model(8'b10101100, 1'b1, 2));
        @(negedge CLK);
        DOUT_READY = 1'b0;
        #2 N_RESET = 1'b0;
        #1;
        chk("ar_dout", DOUT, 0);
        chk("ar_valid", DOUT_VALID, 0);
        chk("ar_busy", BUSY, 0);
        chk("ar_done", DONE, 0);
        @(negedge CLK);
        N_RESET = 1'b1;
        last_word = '0;
        run(8'b00000001, 1'b0, 1, 0, 1'b0);   // first word 00001000

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
